calendar_core: RTL and testbench
================================

Name: calendar_core

Overview:
- Parametrised date engine for the digital clock: holds year/month/day, advances on a one-cycle day tick, and supports interactive field editing (increment and decrement).
- Applies full Gregorian leap rules over a configurable year window and provides a registered weekday and per-field blink select.
- Sits between the time-of-day counter (source of the day tick), the control state machine (set_en/shift/inc/dec) and the display module.

Parameters:
- YEAR_W, 12, width of the year output (must hold YEAR_MAX).
- YEAR_MIN, 2000, lowest representable year; wrap target.
- YEAR_MAX, 2099, highest representable year.
- RESET_YEAR, 2017, year after reset (YEAR_MIN..YEAR_MAX).
- RESET_MONTH, 1, month after reset.
- RESET_DAY, 1, day after reset (must be valid for RESET_MONTH/RESET_YEAR).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- day_tick  in  1  single-cycle pulse; advance date by one day.
- set_en  in  1  level; high = edit mode.
- set_shift  in  1  pulse; select next field.
- set_inc  in  1  pulse; increment selected field.
- set_dec  in  1  pulse; decrement selected field.
- out_year  out  YEAR_W  full year, binary.
- out_month  out  4  month 1..12.
- out_day  out  5  day 1..31.
- out_week  out  3  weekday, 0=Sunday..6=Saturday.
- blink  out  2  0 = none, 1 = year, 2 = month, 3 = day.
- year_wrap  out  1  one-cycle pulse when YEAR_MAX wraps to YEAR_MIN by advance.

Behaviour:
- Reset (asynchronous, active-low; applies even mid-edit):
  - date = RESET_YEAR/RESET_MONTH/RESET_DAY.
  - FSM = IDLE, blink = 0, year_wrap = 0.
  - out_week = weekday of the reset date (2017-01-01 → 0).
- Leap year: divisible by 4 and (not divisible by 100 or divisible by 400).
- days_in_month: 31/28-29/31/30/31/30/31/31/30/31/30/31.
- FSM states: IDLE, SET_YEAR, SET_MONTH, SET_DAY.
  - IDLE → SET_YEAR when set_en = 1.
  - Any SET_* → IDLE when set_en = 0; the edge takes priority over shift/inc/dec in the same cycle.
  - On set_shift: SET_YEAR → SET_MONTH → SET_DAY → SET_YEAR.
- blink is registered from the FSM state: IDLE = 0, SET_YEAR = 1, SET_MONTH = 2, SET_DAY = 3.
- Advance, IDLE only:
  - All outputs update on the edge after the day_tick cycle (1-cycle latency).
  - day < days_in_month: day+1.
  - Otherwise day = 1 and month+1.
  - From month 12: month = 1, year+1.
  - From year YEAR_MAX: year = YEAR_MIN and year_wrap pulses for one cycle.
  - day_tick while in any SET_* state is discarded; no deferred advance.
- Edit, SET_* only, one step per pulse:
  - inc and dec asserted in the same cycle: no change.
  - Year wraps YEAR_MAX↔YEAR_MIN. Month wraps 12↔1. Day wraps days_in_month↔1 with no carry into month or year.
  - No year_wrap pulse from edits.
  - Pulse in the same cycle as set_shift: applies to the field selected before the shift.
- Day clamp: after any year or month change, if day > new days_in_month, day = days_in_month in the same update (e.g. 2016-02-29, year+1 → 2017-02-28).
- Weekday:
  - Computed from the next-state date and registered alongside the date, so it is never stale.
  - Zeller-style: months 1-2 treated as 13-14 of the previous year; century term included; mod 7 mapped to 0=Sunday.
- Widths: internal arithmetic is YEAR_W+4 bits to avoid overflow; all outputs are binary (BCD conversion belongs to the display module).

Decomposition:
- Package cal_pkg:
  - typedef enum cal_field_e {IDLE, SET_YEAR, SET_MONTH, SET_DAY};
  - month constants;
  - functions is_leap(year), days_in_month(year, month), weekday(year, month, day).
- One sub-module, cal_month_len: combinational days_in_month and leap, instanced once for the next-state path; it feeds both clamping and advance.

Test Plan:
- Reset with defaults → 2017-01-01, out_week = 0, blink = 0. Assert rst_n mid-edit → same values and FSM IDLE next cycle.
- Load 2000-02-28 via edits, drop set_en, one day_tick → 2000-02-29 (Tue, out_week = 2). Second tick → 2000-03-01. From 2100-type non-leap check: set 2099-02-28 + tick → 2099-03-01.
- Set 2099-12-31, tick → 2000-01-01, year_wrap high exactly one cycle, out_week = 6.
- Edit 2017-03-31: shift to month, one dec → 2017-02-28. Shift to day, inc → 2017-02-01 with month unchanged.
- In SET_DAY, assert inc+dec together → no change. day_tick while set_en = 1 → date unchanged after exit.
- set_en rise → blink = 1. Three set_shift pulses → blink 2, 3, 1. set_en fall with inc in the same cycle → blink = 0, year unchanged.

Source files
------------

// File: rtl/cal_pkg.sv
// -----------------------------------------------------------------------------
// cal_pkg
// Shared types and calendar arithmetic for the date engine.
//   cal_field_e    : edit FSM state; the encoding doubles as the blink code
//                    (0 none, 1 year, 2 month, 3 day).
//   MONTH_*        : month numbers used by the length and wrap logic.
//   is_leap        : full Gregorian leap rule.
//   days_in_month  : month length for a given year and month.
//   weekday        : Zeller congruence remapped to 0=Sunday..6=Saturday.
// The functions take a 32-bit year so they work for any year width up to that.
// -----------------------------------------------------------------------------
package cal_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_YEAR  = 2'd1,
        SET_MONTH = 2'd2,
        SET_DAY   = 2'd3
    } cal_field_e;

    localparam logic [3:0] MONTH_JAN = 4'd1;
    localparam logic [3:0] MONTH_FEB = 4'd2;
    localparam logic [3:0] MONTH_APR = 4'd4;
    localparam logic [3:0] MONTH_JUN = 4'd6;
    localparam logic [3:0] MONTH_SEP = 4'd9;
    localparam logic [3:0] MONTH_NOV = 4'd11;
    localparam logic [3:0] MONTH_DEC = 4'd12;

    function automatic logic is_leap(input logic [31:0] year);
        return (year % 32'd4 == 32'd0) &&
               ((year % 32'd100 != 32'd0) || (year % 32'd400 == 32'd0));
    endfunction

    function automatic logic [4:0] days_in_month(input logic [31:0] year,
                                                 input logic [3:0]  month);
        logic [4:0] len;
        case (month)
            MONTH_FEB:                               len = is_leap(year) ? 5'd29 : 5'd28;
            MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: len = 5'd30;
            default:                                 len = 5'd31;
        endcase
        return len;
    endfunction

    function automatic logic [2:0] weekday(input logic [31:0] year,
                                           input logic [3:0]  month,
                                           input logic [4:0]  day);
        logic [31:0] y;
        logic [31:0] m;
        logic [31:0] k;
        logic [31:0] j;
        logic [31:0] h;
        // January and February count as months 13 and 14 of the previous year.
        if (month <= MONTH_FEB) begin
            y = year - 32'd1;
            m = 32'(month) + 32'd12;
        end else begin
            y = year;
            m = 32'(month);
        end
        k = y % 32'd100;
        j = y / 32'd100;
        h = (32'(day) + (32'd13 * (m + 32'd1)) / 32'd5 + k + k / 32'd4 +
             j / 32'd4 + 32'd5 * j) % 32'd7;
        // Zeller yields 0=Saturday; rotate so that 0=Sunday.
        return 3'((h + 32'd6) % 32'd7);
    endfunction

endpackage

// File: rtl/cal_month_len.sv
// -----------------------------------------------------------------------------
// cal_month_len
// Combinational month length (leap-aware) for the candidate next-state date.
//   year  in  YEAR_W  candidate year, binary
//   month in  4       candidate month 1..12
//   dim   out 5       number of days in that month
// -----------------------------------------------------------------------------
module cal_month_len
    import cal_pkg::*;
#(
    parameter int YEAR_W = 16
) (
    input  logic [YEAR_W-1:0] year,
    input  logic [3:0]        month,
    output logic [4:0]        dim
);

    assign dim = days_in_month(32'(year), month);

endmodule

// File: rtl/calendar_core.sv
// -----------------------------------------------------------------------------
// calendar_core
// Date engine: holds year/month/day, advances on day_tick while idle, and lets
// the control FSM edit one field at a time with wrap-around inc/dec.
//   clk, rst_n     clock, asynchronous active-low reset
//   day_tick       one-cycle pulse, advance one day (ignored while editing)
//   set_en         level, edit mode
//   set_shift      pulse, select next field year->month->day->year
//   set_inc/dec    pulse, step the selected field (both together = no-op)
//   out_year/month/day  registered binary date
//   out_week       registered weekday of the same date, 0=Sunday
//   blink          field being edited (0 none, 1 year, 2 month, 3 day)
//   year_wrap      one-cycle pulse when an advance wraps YEAR_MAX->YEAR_MIN
// -----------------------------------------------------------------------------
module calendar_core
    import cal_pkg::*;
#(
    parameter int YEAR_W      = 12,
    parameter int YEAR_MIN    = 2000,
    parameter int YEAR_MAX    = 2099,
    parameter int RESET_YEAR  = 2017,
    parameter int RESET_MONTH = 1,
    parameter int RESET_DAY   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
    input  logic              set_en,
    input  logic              set_shift,
    input  logic              set_inc,
    input  logic              set_dec,
    output logic [YEAR_W-1:0] out_year,
    output logic [3:0]        out_month,
    output logic [4:0]        out_day,
    output logic [2:0]        out_week,
    output logic [1:0]        blink,
    output logic              year_wrap
);

    localparam int CW = YEAR_W + 4;
    localparam logic [CW-1:0] Y_MIN      = CW'(YEAR_MIN);
    localparam logic [CW-1:0] Y_MAX      = CW'(YEAR_MAX);
    localparam logic [2:0]    RESET_WEEK = weekday(32'(RESET_YEAR), 4'(RESET_MONTH),
                                                   5'(RESET_DAY));

    cal_field_e    state, state_nxt;
    logic          advance, edit_step, wrap_nxt;
    logic [CW-1:0] year_cur, cand_year, year_nxt;
    logic [3:0]    cand_month, month_nxt;
    logic [4:0]    dim, day_nxt;
    logic [2:0]    week_nxt;

    assign year_cur  = CW'(out_year);
    assign advance   = (state == IDLE) && day_tick;
    // The set_en fall wins over any edit pulse in the same cycle.
    assign edit_step = (state != IDLE) && set_en && (set_inc != set_dec);

    // Edit FSM next state.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (set_en) state_nxt = SET_YEAR;
        end else if (!set_en) begin
            state_nxt = IDLE;
        end else if (set_shift) begin
            case (state)
                SET_YEAR:  state_nxt = SET_MONTH;
                SET_MONTH: state_nxt = SET_DAY;
                default:   state_nxt = SET_YEAR;
            endcase
        end
    end

    // Candidate year/month: the edited field, otherwise the current date. The
    // month length of this candidate serves both the day clamp after a
    // year/month edit and the end-of-month test of an advance.
    always_comb begin
        cand_year  = year_cur;
        cand_month = out_month;
        if (edit_step) begin
            case (state)
                SET_YEAR:
                    if (set_inc) cand_year = (year_cur == Y_MAX) ? Y_MIN : year_cur + CW'(1);
                    else         cand_year = (year_cur == Y_MIN) ? Y_MAX : year_cur - CW'(1);
                SET_MONTH:
                    if (set_inc) cand_month = (out_month == MONTH_DEC) ? MONTH_JAN : out_month + 4'd1;
                    else         cand_month = (out_month == MONTH_JAN) ? MONTH_DEC : out_month - 4'd1;
                default: ;
            endcase
        end
    end

    cal_month_len #(.YEAR_W(CW)) u_month_len (
        .year  (cand_year),
        .month (cand_month),
        .dim   (dim)
    );

    always_comb begin
        year_nxt  = cand_year;
        month_nxt = cand_month;
        day_nxt   = out_day;
        wrap_nxt  = 1'b0;
        if (advance) begin
            if (out_day < dim) begin
                day_nxt = out_day + 5'd1;
            end else begin
                day_nxt = 5'd1;
                if (out_month == MONTH_DEC) begin
                    month_nxt = MONTH_JAN;
                    if (year_cur == Y_MAX) begin
                        year_nxt = Y_MIN;
                        wrap_nxt = 1'b1;
                    end else begin
                        year_nxt = year_cur + CW'(1);
                    end
                end else begin
                    month_nxt = out_month + 4'd1;
                end
            end
        end else if (edit_step) begin
            if (state == SET_DAY) begin
                if (set_inc) day_nxt = (out_day == dim)   ? 5'd1 : out_day + 5'd1;
                else         day_nxt = (out_day == 5'd1)  ? dim  : out_day - 5'd1;
            end else if (out_day > dim) begin
                day_nxt = dim;
            end
        end
    end

    // Weekday follows the next-state date so it lands in the same edge.
    assign week_nxt = weekday(32'(year_nxt), month_nxt, day_nxt);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_year  <= YEAR_W'(RESET_YEAR);
            out_month <= 4'(RESET_MONTH);
            out_day   <= 5'(RESET_DAY);
            out_week  <= RESET_WEEK;
            year_wrap <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_year  <= year_nxt[YEAR_W-1:0];
            out_month <= month_nxt;
            out_day   <= day_nxt;
            out_week  <= week_nxt;
            year_wrap <= wrap_nxt;
        end
    end

    // The state register's encoding is the blink code, so blink is registered.
    assign blink = state;

endmodule

// File: tb/tb_calendar_core.sv
// -----------------------------------------------------------------------------
// tb_calendar_core
// Self-checking bench. The reference model keeps the date as a day number
// counted from YEAR_MIN-01-01: an advance is "serial + 1", the weekday is the
// serial offset from a known Saturday, and edits are modular steps on the
// selected field. A compare process checks every output on every falling edge
// out of reset; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_calendar_core;

    localparam int YEAR_W   = 12;
    localparam int YEAR_MIN = 2000;
    localparam int YEAR_MAX = 2099;
    localparam int YSPAN    = YEAR_MAX - YEAR_MIN + 1;
    localparam int BASE_WD  = 6;   // 2000-01-01 was a Saturday

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              day_tick = 1'b0;
    logic              set_en = 1'b0;
    logic              set_shift = 1'b0;
    logic              set_inc = 1'b0;
    logic              set_dec = 1'b0;
    logic [YEAR_W-1:0] out_year;
    logic [3:0]        out_month;
    logic [4:0]        out_day;
    logic [2:0]        out_week;
    logic [1:0]        blink;
    logic              year_wrap;

    int checks   = 0;
    int failures = 0;

    // Reference model state (mode: 0 idle, 1 year, 2 month, 3 day).
    int m_year, m_month, m_day, m_mode, m_wrap;
    bit en_r = 1'b0;

    calendar_core #(
        .YEAR_W(YEAR_W), .YEAR_MIN(YEAR_MIN), .YEAR_MAX(YEAR_MAX),
        .RESET_YEAR(2017), .RESET_MONTH(1), .RESET_DAY(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .day_tick  (day_tick),
        .set_en    (set_en),
        .set_shift (set_shift),
        .set_inc   (set_inc),
        .set_dec   (set_dec),
        .out_year  (out_year),
        .out_month (out_month),
        .out_day   (out_day),
        .out_week  (out_week),
        .blink     (blink),
        .year_wrap (year_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: dut=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- calendar arithmetic ----------------
    function automatic bit leap(input int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int dim(input int y, input int m);
        int len [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && leap(y)) return 29;
        return len[m-1];
    endfunction

    function automatic int year_len(input int y);
        return leap(y) ? 366 : 365;
    endfunction

    function automatic int serial(input int y, input int m, input int d);
        int n = 0;
        for (int yy = YEAR_MIN; yy < y; yy++) n += year_len(yy);
        for (int mm = 1; mm < m; mm++) n += dim(y, mm);
        return n + d - 1;
    endfunction

    function automatic int window_days();
        return serial(YEAR_MAX, 12, 31) + 1;
    endfunction

    task automatic from_serial(input int n, output int y, output int m, output int d);
        int rem = n;
        y = YEAR_MIN;
        while (rem >= year_len(y)) begin
            rem -= year_len(y);
            y++;
        end
        m = 1;
        while (rem >= dim(y, m)) begin
            rem -= dim(y, m);
            m++;
        end
        d = rem + 1;
    endtask

    function automatic int wrap_step(input int v, input bit up, input int lo, input int hi);
        int span = hi - lo + 1;
        return lo + ((v - lo + (up ? 1 : span - 1)) % span);
    endfunction

    // ---------------- reference model ----------------
    task automatic model_step(input bit tick, input bit en, input bit sh,
                              input bit inc, input bit dec);
        int old = m_mode;
        int n;
        m_wrap = 0;
        if (old == 0) begin
            if (tick) begin
                n = serial(m_year, m_month, m_day) + 1;
                if (n == window_days()) begin
                    n = 0;
                    m_wrap = 1;
                end
                from_serial(n, m_year, m_month, m_day);
            end
            if (en) m_mode = 1;
        end else if (!en) begin
            m_mode = 0;
        end else begin
            if (inc != dec) begin
                case (old)
                    1:       m_year  = wrap_step(m_year, inc, YEAR_MIN, YEAR_MAX);
                    2:       m_month = wrap_step(m_month, inc, 1, 12);
                    default: m_day   = wrap_step(m_day, inc, 1, dim(m_year, m_month));
                endcase
                if (m_day > dim(m_year, m_month)) m_day = dim(m_year, m_month);
            end
            if (sh) m_mode = (old == 3) ? 1 : old + 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_year  = 2017;
            m_month = 1;
            m_day   = 1;
            m_mode  = 0;
            m_wrap  = 0;
        end else begin
            model_step(day_tick, set_en, set_shift, set_inc, set_dec);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("year",  32'(out_year),  m_year);
            check("month", 32'(out_month), m_month);
            check("day",   32'(out_day),   m_day);
            check("week",  32'(out_week),  (BASE_WD + serial(m_year, m_month, m_day)) % 7);
            check("blink", 32'(blink),     m_mode);
            check("wrap",  32'(year_wrap), m_wrap);
        end
    end

    // ---------------- stimulus ----------------
    // Called at a falling edge; drives one cycle and returns at the next
    // falling edge, when the resulting outputs are settled.
    task automatic step(input bit tick, input bit en, input bit sh, input bit inc, input bit dec);
        day_tick  = tick;
        set_en    = en;
        set_shift = sh;
        set_inc   = inc;
        set_dec   = dec;
        @(negedge clk);
    endtask

    // Edit the date to y-m-d along the shorter wrap direction; ends in SET_DAY.
    task automatic goto_date(input int y, input int m, input int d);
        int fwd;
        int span;
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        fwd = ((y - m_year) % YSPAN + YSPAN) % YSPAN;
        if (fwd <= YSPAN / 2) repeat (fwd) step(0, 1, 0, 1, 0);
        else                  repeat (YSPAN - fwd) step(0, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        fwd = ((m - m_month) % 12 + 12) % 12;
        if (fwd <= 6) repeat (fwd) step(0, 1, 0, 1, 0);
        else          repeat (12 - fwd) step(0, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        span = dim(y, m);
        fwd = ((d - m_day) % span + span) % span;
        if (fwd <= span / 2) repeat (fwd) step(0, 1, 0, 1, 0);
        else                 repeat (span - fwd) step(0, 1, 0, 0, 1);
    endtask

    task automatic pin_date(input string tag, input int y, input int m, input int d);
        check({tag, "_year"},  32'(out_year),  y);
        check({tag, "_month"}, 32'(out_month), m);
        check({tag, "_day"},   32'(out_day),   d);
    endtask

    initial begin
        // Reset values.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        pin_date("rst", 2017, 1, 1);
        check("rst_week",  32'(out_week),  0);
        check("rst_blink", 32'(blink),     0);
        check("rst_wrap",  32'(year_wrap), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Field selection sequence.
        step(0, 1, 0, 0, 0); check("blink_en",  32'(blink), 1);
        step(0, 1, 1, 0, 0); check("blink_sh1", 32'(blink), 2);
        step(0, 1, 1, 0, 0); check("blink_sh2", 32'(blink), 3);
        step(0, 1, 1, 0, 0); check("blink_sh3", 32'(blink), 1);
        step(0, 0, 0, 1, 0); check("blink_off", 32'(blink), 0);
        check("exit_inc_year", 32'(out_year), 2017);

        // Leap day in a %400 year.
        goto_date(2000, 2, 28);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0); pin_date("leap", 2000, 2, 29);
        check("leap_week", 32'(out_week), 2);
        step(1, 0, 0, 0, 0); pin_date("mar", 2000, 3, 1);
        check("mar_week", 32'(out_week), 3);

        // Non-leap February.
        goto_date(2099, 2, 28);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0); pin_date("noleap", 2099, 3, 1);

        // Year window wrap.
        goto_date(2099, 12, 31);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0); pin_date("ywrap", 2000, 1, 1);
        check("ywrap_week", 32'(out_week),  6);
        check("ywrap_hi",   32'(year_wrap), 1);
        step(0, 0, 0, 0, 0); check("ywrap_lo", 32'(year_wrap), 0);

        // Month decrement clamps the day; day edit wraps without carry.
        goto_date(2017, 3, 31);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 1); pin_date("clamp", 2017, 2, 28);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 1, 0); pin_date("daywrap", 2017, 2, 1);
        step(0, 1, 0, 1, 1); pin_date("incdec", 2017, 2, 1);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0); pin_date("tick_in_edit", 2017, 2, 1);

        // Reset in the middle of an edit.
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        set_en = 1'b0; set_inc = 1'b0; day_tick = 1'b0; set_shift = 1'b0; set_dec = 1'b0;
        #1;
        pin_date("midrst", 2017, 1, 1);
        check("midrst_blink", 32'(blink), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        step(0, 0, 0, 0, 0);
        check("postrst_blink", 32'(blink), 0);
        pin_date("postrst", 2017, 1, 1);

        // Randomized traffic near the end of the window, then anywhere.
        goto_date(2099, 12, 20);
        step(0, 0, 0, 0, 0);
        en_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) en_r = ~en_r;
            step(1'($urandom_range(0, 1)), en_r,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
